status_counters: RTL and testbench
==================================

// Module: status_counters
// PURPOSE
//   Datapath counter stage that feeds the game controller (FSM). It counts the
//   FPGA sequence display, the user's entries, the round level and the
//   per-entry time budget. It returns the end_fpga, end_user, end_time and win
//   status flags to the FSM, and takes the FSM commands r1/r2/e1..e4 as inputs.
// PARAMETERS
//   CLK_HZ     50_000_000  input clock frequency (clock_50)
//   TICK_HZ    1           display/time-base rate; prescaler period = CLK_HZ/TICK_HZ
//   TIME_LIMIT 10          ticks allowed per user entry (1..2**TIME_W-1)
//   TIME_W     4           width of time_left
//   MAX_LEVEL  15          last level; completing it sets win
//   LVL_W      4           width of level/seq_idx/user_idx (MAX_LEVEL < 2**LVL_W)
// PORTS
//   clock_50  in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset (0 = reset)
//   r1        in   1      sync round clear: seq_idx, user_idx, flags, timer, prescaler
//   r2        in   1      sync game clear: everything r1 clears, plus level and win
//   e1        in   1      level: FPGA sequence display running (advances on tick)
//   e2        in   1      level: user time budget running (decrements on tick)
//   e3        in   1      pulse: one user entry accepted
//   e4        in   1      pulse: round passed, advance level
//   end_fpga  out  1      sequence fully shown (registered, sticky)
//   end_user  out  1      user entered level+1 items (registered, sticky)
//   end_time  out  1      time_left reached 0 (registered)
//   win       out  1      MAX_LEVEL completed (registered, sticky)
//   tick      out  1      1-cycle prescaler pulse
//   seq_idx   out  LVL_W  index of the sequence item currently displayed
//   user_idx  out  LVL_W  number of user entries so far this round
//   level     out  LVL_W  current level (the round shows level+1 items)
//   time_left out  TIME_W remaining ticks for the current entry
// BEHAVIOUR
//   Reset (reset=0, async): all counters 0, time_left=TIME_LIMIT, all flags 0, tick 0.
//   Priority every cycle: r2 > r1 > e-commands. r2 implies r1.
//   Prescaler: counts 0..P-1 (P=CLK_HZ/TICK_HZ) only while e1|e2.
//     - tick=1 for the one cycle after the count wraps from P-1 to 0.
//     - Held at 0 while neither e1 nor e2 is high, or when r1/r2 is high.
//     - First tick arrives P cycles after the enable rises.
//   Sequence: on tick with e1=1 and end_fpga=0:
//     - if seq_idx==level, set end_fpga=1 and hold seq_idx;
//     - else seq_idx+=1.
//   User: on e3=1 with end_user=0:
//     - if user_idx==level, set end_user=1;
//     - user_idx+=1, saturating at 2**LVL_W-1.
//     - e3 is ignored while end_user=1.
//   Timer:
//     - e3 reloads time_left=TIME_LIMIT and clears end_time.
//     - Else, on tick with e2=1 and time_left!=0: time_left-=1.
//     - end_time=1 in the cycle after time_left becomes 0; it holds until e3 or r1/r2.
//     - e3 and a tick in the same cycle: the reload wins.
//   Level: on e4=1:
//     - if level==MAX_LEVEL, set win=1 and keep level;
//     - else level+=1.
//     - e4 also performs an implicit r1 (round clear) in the same cycle.
//     - e4 while win=1 has no effect.
//   r1: clears seq_idx, user_idx, end_fpga, end_user and end_time, reloads
//       time_left and clears the prescaler. It keeps level and win.
//   r2: does everything r1 does, and also clears level and win.
//   Simultaneous e1 and e2: both counters advance on the same tick.
//   No combinational path from inputs to outputs. All outputs are registered.
// TESTING (bench uses CLK_HZ=8, TICK_HZ=1, i.e. P=8)
//   1. Assert reset=0 mid-count with level=3 -> every output returns to its reset
//      value without waiting for a clock edge; time_left=10.
//   2. level=2, e1=1 -> tick every 8 cycles; seq_idx goes 1,2; end_fpga=1 on the
//      3rd tick; seq_idx stays 2 on later ticks.
//   3. level=1: 2 e3 pulses -> end_user=1, user_idx=2; a 3rd e3 -> no change.
//   4. e2=1, no e3 -> time_left counts 10 down to 0 after 80 cycles; end_time=1 the
//      next cycle. Then e3 -> time_left=10, end_time=0. e3 coincident with a tick
//      -> time_left=10.
//   5. 15 e4 pulses -> level=15, win=0; a 16th e4 -> win=1, level=15; then
//      r2 -> level=0, win=0.
//   6. r1 and e3 in the same cycle -> user_idx=0, end_user=0 (r1 wins);
//      r1 with level=5 -> level stays 5.

Source files
------------

// File: rtl/status_counters.sv
// Counter stage for the memory-game controller: sequence display, user entries,
// round level and per-entry time budget, with registered status flags.
module status_counters #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int TIME_LIMIT = 10,
  parameter int TIME_W     = 4,
  parameter int MAX_LEVEL  = 15,
  parameter int LVL_W      = 4
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              r1,
  input  logic              r2,
  input  logic              e1,
  input  logic              e2,
  input  logic              e3,
  input  logic              e4,
  output logic              end_fpga,
  output logic              end_user,
  output logic              end_time,
  output logic              win,
  output logic              tick,
  output logic [LVL_W-1:0]  seq_idx,
  output logic [LVL_W-1:0]  user_idx,
  output logic [LVL_W-1:0]  level,
  output logic [TIME_W-1:0] time_left
);

  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0]     PMAX  = PW'(P - 1);
  localparam logic [TIME_W-1:0] TLIM  = TIME_W'(TIME_LIMIT);
  localparam logic [LVL_W-1:0]  LMAX  = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]  USAT  = '1;

  logic [PW-1:0]     cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [LVL_W-1:0]  seq_q, seq_d;
  logic [LVL_W-1:0]  user_q, user_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              efpga_q, efpga_d;
  logic              euser_q, euser_d;
  logic              etime_q, etime_d;
  logic              win_q, win_d;
  logic              adv;
  logic              round_clr;

  // A level advance (e4 before win) also clears the round.
  assign adv       = e4 && !win_q;
  assign round_clr = r1 || r2 || adv;

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    seq_d   = seq_q;
    user_d  = user_q;
    level_d = level_q;
    time_d  = time_q;
    efpga_d = efpga_q;
    euser_d = euser_q;
    etime_d = etime_q;
    win_d   = win_q;

    if (r2) begin
      level_d = '0;
      win_d   = 1'b0;
    end else if (!r1 && adv) begin
      if (level_q == LMAX) win_d = 1'b1;
      else                 level_d = level_q + LVL_W'(1);
    end

    if (round_clr) begin
      cnt_d   = '0;
      seq_d   = '0;
      user_d  = '0;
      time_d  = TLIM;
      efpga_d = 1'b0;
      euser_d = 1'b0;
      etime_d = 1'b0;
    end else begin
      if (e1 || e2) begin
        cnt_d  = (cnt_q == PMAX) ? '0 : cnt_q + PW'(1);
        tick_d = (cnt_q == PMAX);
      end else begin
        cnt_d = '0;
      end

      if (tick_q && e1 && !efpga_q) begin
        if (seq_q == level_q) efpga_d = 1'b1;
        else                  seq_d = seq_q + LVL_W'(1);
      end

      if (e3 && !euser_q) begin
        if (user_q == level_q) euser_d = 1'b1;
        if (user_q != USAT)    user_d = user_q + LVL_W'(1);
      end

      if (e3) begin
        time_d  = TLIM;
        etime_d = 1'b0;
      end else begin
        if (tick_q && e2 && time_q != '0) time_d = time_q - TIME_W'(1);
        etime_d = (time_q == '0);
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      seq_q   <= '0;
      user_q  <= '0;
      level_q <= '0;
      time_q  <= TLIM;
      efpga_q <= 1'b0;
      euser_q <= 1'b0;
      etime_q <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      seq_q   <= seq_d;
      user_q  <= user_d;
      level_q <= level_d;
      time_q  <= time_d;
      efpga_q <= efpga_d;
      euser_q <= euser_d;
      etime_q <= etime_d;
      win_q   <= win_d;
    end
  end

  assign end_fpga  = efpga_q;
  assign end_user  = euser_q;
  assign end_time  = etime_q;
  assign win       = win_q;
  assign tick      = tick_q;
  assign seq_idx   = seq_q;
  assign user_idx  = user_q;
  assign level     = level_q;
  assign time_left = time_q;

endmodule

// File: tb/tb_status_counters.sv
// Directed bench for status_counters with an 8-cycle prescaler.
module tb_status_counters;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r1, r2, e1, e2, e3, e4;
  logic       end_fpga, end_user, end_time, win, tick;
  logic [3:0] seq_idx, user_idx, level, time_left;

  int vecs = 0;
  int errs = 0;

  status_counters #(
    .CLK_HZ(8), .TICK_HZ(1), .TIME_LIMIT(10),
    .TIME_W(4), .MAX_LEVEL(15), .LVL_W(4)
  ) dut (
    .clock_50(clk), .reset(rst_n),
    .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4),
    .end_fpga(end_fpga), .end_user(end_user),
    .end_time(end_time), .win(win), .tick(tick),
    .seq_idx(seq_idx), .user_idx(user_idx),
    .level(level), .time_left(time_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_e3();
    e3 = 1'b1; step(); e3 = 1'b0;
  endtask

  task automatic pulse_e4();
    e4 = 1'b1; step(); e4 = 1'b0;
  endtask

  task automatic pulse_r1();
    r1 = 1'b1; step(); r1 = 1'b0;
  endtask

  task automatic pulse_r2();
    r2 = 1'b1; step(); r2 = 1'b0;
  endtask

  // Steps until tick is seen; n is the number of edges taken, -1 on timeout.
  task automatic wait_tick(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    {r1, r2, e1, e2, e3, e4} = '0;
    #12;
    chk("rst_time_left", time_left, 10);
    chk("rst_level", level, 0);
    chk("rst_flags", {end_fpga, end_user, end_time, win, tick}, 0);
    rst_n = 1'b1;
    step();

    // level walk to MAX, then win, then game clear
    for (int i = 0; i < 15; i++) pulse_e4();
    chk("lvl15_level", level, 15);
    chk("lvl15_win", win, 0);
    pulse_e4();
    chk("lvl16_win", win, 1);
    chk("lvl16_level", level, 15);
    pulse_e4();
    chk("win_e4_level", level, 15);
    pulse_r2();
    chk("r2_level", level, 0);
    chk("r2_win", win, 0);

    // sequence display at level 2
    pulse_e4();
    pulse_e4();
    chk("seq_level", level, 2);
    e1 = 1'b1;
    wait_tick(n);
    chk("first_tick_lat", n, 8);
    step();
    chk("seq_t1", seq_idx, 1);
    chk("tick_1cyc", tick, 0);
    wait_tick(n);
    chk("tick_period", n, 7);
    step();
    chk("seq_t2", seq_idx, 2);
    chk("fpga_t2", end_fpga, 0);
    wait_tick(n);
    step();
    chk("seq_t3", seq_idx, 2);
    chk("fpga_t3", end_fpga, 1);
    wait_tick(n);
    step();
    chk("seq_t4", seq_idx, 2);
    chk("fpga_t4", end_fpga, 1);
    e1 = 1'b0;
    pulse_r1();
    chk("r1_fpga", end_fpga, 0);
    chk("r1_seq", seq_idx, 0);
    chk("r1_keeps_lvl", level, 2);

    // user entries at level 1
    pulse_r2();
    pulse_e4();
    chk("usr_level", level, 1);
    pulse_e3();
    chk("usr_e1_idx", user_idx, 1);
    chk("usr_e1_end", end_user, 0);
    pulse_e3();
    chk("usr_e2_idx", user_idx, 2);
    chk("usr_e2_end", end_user, 1);
    pulse_e3();
    chk("usr_e3_idx", user_idx, 2);
    chk("usr_e3_end", end_user, 1);

    // r1 beats e3; r1 keeps level
    for (int i = 0; i < 4; i++) pulse_e4();
    chk("lvl5", level, 5);
    pulse_e3();
    chk("pre_r1_idx", user_idx, 1);
    r1 = 1'b1; e3 = 1'b1;
    step();
    r1 = 1'b0; e3 = 1'b0;
    chk("r1e3_idx", user_idx, 0);
    chk("r1e3_end", end_user, 0);
    chk("r1_lvl5", level, 5);

    // time budget
    e2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_tick(n);
      if (i == 0) chk("tmr_first_lat", n, 8);
      step();
      chk($sformatf("tmr_dec%0d", i), time_left, 9 - i);
    end
    chk("tmr_end0", end_time, 0);
    step();
    chk("tmr_end1", end_time, 1);
    wait_tick(n);
    step();
    chk("tmr_hold0", time_left, 0);
    chk("tmr_hold_end", end_time, 1);
    pulse_e3();
    chk("tmr_reload", time_left, 10);
    chk("tmr_end_clr", end_time, 0);
    wait_tick(n);
    e3 = 1'b1;
    step();
    e3 = 1'b0;
    chk("tmr_e3_tick", time_left, 10);
    e2 = 1'b0;

    // asynchronous reset mid-count at level 3
    pulse_r2();
    for (int i = 0; i < 3; i++) pulse_e4();
    pulse_e3();
    e1 = 1'b1; e2 = 1'b1;
    wait_tick(n);
    step();
    step();
    chk("pre_rst_lvl", level, 3);
    chk("pre_rst_seq", seq_idx, 1);
    chk("pre_rst_time", time_left, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_seq", seq_idx, 0);
    chk("arst_user", user_idx, 0);
    chk("arst_time", time_left, 10);
    chk("arst_flags", {end_fpga, end_user, end_time, win, tick}, 0);
    e1 = 1'b0; e2 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
